mips_multicycle_core: RTL and testbench

Parametrised multi-cycle MIPS-subset core: a five-state FSM (fetch, decode, execute, memory, writeback) replaces the free-running PC and one-instruction datapath of the earlier core. Sits between the synchronous-read instruction memory and the four byte-lane data memories. Holds an internal 32-entry register file. Exposes the PC plus retire/halt strobes for debug and bench checking.

---
 rtl/mips_multicycle_core_if.sv | 17 +
 rtl/mips_multicycle_core.sv | 172 +++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_core_if.sv
// Memory-side bus of the multi-cycle MIPS core: instruction fetch port plus
// the four byte-lane data memory port. master = core, slave = memories.
interface mips_multicycle_core_if #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
);
  logic [PC_W-3:0]    iaddr;
  logic [31:0]        instr;
  logic [DADDR_W-3:0] daddr;
  logic [XLEN-1:0]    dout;
  logic [XLEN/8-1:0]  wr;
  logic [XLEN-1:0]    din;

  modport master (output iaddr, daddr, dout, wr, input instr, din);
  modport slave  (input iaddr, daddr, dout, wr, output instr, din);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM with an internal
// 32-entry register file; an unsupported instruction parks the core in HALT.
module mips_multicycle_core #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  mips_multicycle_core_if.master bus,
  output logic [PC_W-1:0]        pc,
  output logic                   retire,
  output logic                   halt
);
  localparam int NB = XLEN / 8;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_R   = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW  = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_SLT = 6'h2A;

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        ir_q;
  logic [XLEN-1:0]    a_q, b_q, imm_q, imm_d, alu_q, alu_res;
  logic [XLEN-1:0]    rf_q [32];
  logic [DADDR_W-3:0] daddr_q;
  logic [XLEN-1:0]    dout_q;
  logic [NB-1:0]      wr_q;

  // Decode of the raw memory word, used only during DECODE
  logic [5:0] d_op, d_fn;
  logic       d_legal;
  always_comb begin
    d_op    = bus.instr[31:26];
    d_fn    = bus.instr[5:0];
    d_legal = 1'b0;
    case (d_op)
      OP_R: d_legal = d_fn inside {F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB,
                                   F_SUBU, F_AND, F_OR, F_XOR, F_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: d_legal = 1'b1;
      default: d_legal = 1'b0;
    endcase
    if (d_op inside {OP_ANDI, OP_ORI, OP_XORI}) imm_d = XLEN'(bus.instr[15:0]);
    else                                        imm_d = XLEN'($signed(bus.instr[15:0]));
  end

  logic [5:0]      op, fn;
  logic [4:0]      rt, rd, wb_dst;
  logic [31:0]     sh;
  logic            is_br, is_mem, br_take;
  logic [PC_W-1:0] pc_inc, br_tgt, j_tgt;
  logic            unused_rs;

  assign op        = ir_q[31:26];
  assign fn        = ir_q[5:0];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign unused_rs = ^ir_q[25:21];
  assign is_br     = op inside {OP_J, OP_BEQ, OP_BNE};
  assign is_mem    = op inside {OP_LW, OP_SW};
  assign br_take   = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  assign pc_inc    = pc_q + PC_W'(4);
  assign br_tgt    = pc_inc + PC_W'(imm_q << 2);
  assign j_tgt     = {ir_q[PC_W-3:0], 2'b00};
  assign wb_dst    = (op == OP_R) ? rd : rt;

  always_comb begin
    sh      = 32'(ir_q[10:6]) % XLEN;
    alu_res = a_q + imm_q;
    if (op == OP_R) begin
      case (fn)
        F_ADD, F_ADDU: alu_res = a_q + b_q;
        F_SUB, F_SUBU: alu_res = a_q - b_q;
        F_AND:         alu_res = a_q & b_q;
        F_OR:          alu_res = a_q | b_q;
        F_XOR:         alu_res = a_q ^ b_q;
        F_SLT:         alu_res = XLEN'($signed(a_q) < $signed(b_q));
        F_SLL:         alu_res = b_q << sh;
        F_SRL:         alu_res = b_q >> sh;
        F_SRA:         alu_res = $signed(b_q) >>> sh;
        default:       alu_res = a_q + b_q;
      endcase
    end else begin
      case (op)
        OP_SLTI: alu_res = XLEN'($signed(a_q) < $signed(imm_q));
        OP_ANDI: alu_res = a_q & imm_q;
        OP_ORI:  alu_res = a_q | imm_q;
        OP_XORI: alu_res = a_q ^ imm_q;
        default: alu_res = a_q + imm_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = d_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        state_d = is_br ? S_FETCH : (is_mem ? S_MEM : S_WB);
        if (op == OP_J)         pc_d = j_tgt;
        else if (is_br && br_take) pc_d = br_tgt;
        else                    pc_d = pc_inc;
      end
      S_MEM:    state_d = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      daddr_q <= '0;
      dout_q  <= '0;
      wr_q    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wr_q    <= '0;
      case (state_q)
        S_DECODE: begin
          ir_q  <= bus.instr;
          a_q   <= rf_q[bus.instr[25:21]];
          b_q   <= rf_q[bus.instr[20:16]];
          imm_q <= imm_d;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          // Address/data captured here so they are stable for MEM and WB
          if (is_mem) begin
            daddr_q <= alu_res[DADDR_W-1:2];
            dout_q  <= b_q;
            wr_q    <= {NB{op == OP_SW}};
          end
        end
        S_WB: if (wb_dst != 5'd0) rf_q[wb_dst] <= (op == OP_LW) ? bus.din : alu_q;
        default: ;
      endcase
    end
  end

  assign bus.iaddr = pc_q[PC_W-1:2];
  assign bus.daddr = daddr_q;
  assign bus.dout  = dout_q;
  assign bus.wr    = wr_q;
  assign pc        = pc_q;
  assign halt      = (state_q == S_HALT);
  assign retire    = (state_q == S_WB) || (state_q == S_MEM && op == OP_SW) ||
                     (state_q == S_EXEC && is_br);
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed programs for the multi-cycle core; retire timing/next-pc and stores
// are scoreboarded against expectations queued while each program is loaded.
module tb_mips_multicycle_core;
  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] pc;
  logic       retire, halt;

  mips_multicycle_core_if #(.XLEN(32), .PC_W(8), .DADDR_W(8)) bus ();
  mips_multicycle_core #(.XLEN(32), .PC_W(8), .DADDR_W(8)) dut (
    .clk(clk), .nrst(nrst), .bus(bus), .pc(pc), .retire(retire), .halt(halt)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  always @(posedge clk) begin
    bus.instr <= imem[bus.iaddr];
    for (int i = 0; i < 4; i++)
      if (bus.wr[i]) dmem[bus.daddr][8*i +: 8] <= bus.dout[8*i +: 8];
    bus.din <= dmem[bus.daddr];
  end

  typedef struct packed { int len; logic [7:0] npc; } ret_t;
  typedef struct packed { logic [5:0] a; logic [31:0] d; } st_t;
  ret_t ret_q[$];
  st_t  st_q[$];

  int total = 0, bad = 0, cyc = 0, last_ret = 0;
  bit pc_chk = 0;
  logic [7:0] exp_pc, lp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, rt, rd, sh, fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction
  function automatic logic [31:0] enc_i(input int op, rs, rt, imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic put(input logic [31:0] w); imem[lp[7:2]] = w; lp = lp + 8'd4; endtask
  task automatic seq(input logic [31:0] w, input int len); put(w); ret_q.push_back('{len, lp}); endtask
  task automatic jmp(input logic [31:0] w, input logic [7:0] t); put(w); ret_q.push_back('{3, t}); endtask
  task automatic st(input int a, input logic [31:0] d); st_q.push_back('{a[5:0], d}); endtask
  task automatic clear_prog(); for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF; lp = 8'd0; endtask

  // One cycle: sample mid-cycle and score whatever the core produced
  task automatic tick();
    ret_t e;
    st_t  s;
    @(negedge clk);
    cyc++;
    if (pc_chk) begin
      chk("next_pc", pc, exp_pc);
      chk("iaddr", bus.iaddr, exp_pc[7:2]);
      pc_chk = 0;
    end
    if (bus.wr !== 4'd0) begin
      chk("wr_mask", bus.wr, 4'hF);
      chk("store_expected", st_q.size() != 0, 1);
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        chk("st_daddr", bus.daddr, s.a);
        chk("st_dout", bus.dout, s.d);
      end
    end
    if (retire === 1'b1) begin
      chk("retire_expected", ret_q.size() != 0, 1);
      if (ret_q.size() != 0) begin
        e = ret_q.pop_front();
        chk("retire_gap", cyc - last_ret, e.len);
        last_ret = cyc;
        exp_pc   = e.npc;
        pc_chk   = 1;
      end
    end
  endtask

  task automatic run(input bit until_store);
    int n = 0;
    while (n < 3000 && (until_store ? (st_q.size() != 0)
                        : (ret_q.size() != 0 || st_q.size() != 0 || pc_chk))) begin
      tick();
      n++;
    end
    chk("drain", ret_q.size() + st_q.size(), 0);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_iaddr", bus.iaddr, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_halt", halt, 0);
    chk("rst_retire", retire, 0);
    chk("rst_daddr", bus.daddr, 0);
    chk("rst_dout", bus.dout, 0);
    ret_q.delete();
    st_q.delete();
    pc_chk = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 nrst = 1'b1;
    cyc = 0;
    last_ret = 0;
  endtask

  initial begin
    int          rr [14] = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 19, 20, 0};
    logic [31:0] vv [14] = '{32'h6, 32'hF0F0, 32'h8001, 32'hFFFF_0000, 32'hF, 32'h28, 32'h1,
                             32'h8004, 32'hFFFF_0000, 32'h2D, 32'h7FFF, 32'h23, 32'hFFFF_FFFD, 32'h0};
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    #2;

    // Main program: ALU coverage, memory, branches, r0, loop
    do_reset();
    clear_prog();
    seq(enc_i(8, 0, 1, 5), 4);                      // addi r1,r0,5
    seq(enc_i(43, 0, 1, 8), 4);     st(2, 32'h5);   // sw r1,8(r0)
    seq(enc_i(8, 0, 2, -1), 4);                     // addi r2,r0,-1
    seq(enc_r(2, 2, 3, 0, 33), 4);                  // addu r3,r2,r2
    seq(enc_r(2, 0, 4, 0, 42), 4);                  // slt r4,r2,r0
    seq(enc_r(0, 2, 5, 4, 3), 4);                   // sra r5,r2,4
    seq(enc_i(43, 0, 3, 16), 4);    st(4, 32'hFFFF_FFFE);
    seq(enc_i(43, 0, 4, 20), 4);    st(5, 32'h1);
    seq(enc_i(43, 0, 5, 24), 4);    st(6, 32'hFFFF_FFFF);
    seq(enc_i(35, 0, 6, 8), 5);                     // lw r6,8(r0)
    seq(enc_i(43, 0, 6, 28), 4);    st(7, 32'h5);
    seq(enc_r(1, 2, 7, 0, 34), 4);                  // sub
    seq(enc_i(12, 2, 8, 'hF0F0), 4);                // andi (zero-ext)
    seq(enc_i(13, 0, 9, 'h8001), 4);                // ori
    seq(enc_i(14, 2, 10, 'hFFFF), 4);               // xori
    seq(enc_r(0, 2, 11, 28, 2), 4);                 // srl
    seq(enc_r(0, 1, 12, 3, 0), 4);                  // sll
    seq(enc_i(10, 2, 13, 0), 4);                    // slti
    seq(enc_r(1, 9, 14, 0, 38), 4);                 // xor
    seq(enc_r(10, 2, 15, 0, 36), 4);                // and
    seq(enc_r(1, 12, 16, 0, 37), 4);                // or
    seq(enc_i(9, 9, 17, -2), 4);                    // addiu
    seq(enc_r(0, 1, 18, 0, 35), 4);                 // subu
    seq(enc_r(18, 12, 19, 0, 32), 4);               // add
    seq(enc_i(8, 0, 0, 7), 4);                      // addi r0,r0,7
    seq(enc_r(0, 18, 20, 1, 3), 4);                 // sra r20,r18,1
    for (int k = 0; k < 14; k++) begin
      seq(enc_i(43, 0, rr[k], 32 + 4*k), 4);
      st(8 + k, vv[k]);
    end
    seq(enc_i(5, 0, 0, 4), 3);                      // bne not taken (A0)
    jmp(enc_i(4, 1, 1, 1), 8'hAC);                  // beq taken
    put(enc_i(43, 0, 1, 'h58));
    jmp(enc_i(5, 1, 0, 1), 8'hB4);                  // bne taken
    put(enc_i(43, 0, 1, 'h58));
    seq(enc_i(43, 17, 14, -4), 4);  st(62, 32'h8004); // negative offset, low bits ignored
    jmp({6'd2, 26'h30}, 8'hC0);                     // j C0
    put(enc_i(43, 0, 1, 'h58));
    jmp(enc_i(4, 0, 0, -1), 8'hC0);                 // beq r0,r0,-1 loop
    ret_q.push_back('{3, 8'hC0});
    ret_q.push_back('{3, 8'hC0});
    release_rst();
    run(0);

    // Illegal opcode halts; reset clears it
    do_reset();
    clear_prog();
    seq(enc_i(8, 0, 1, 5), 4);
    put(32'hFC00_0000);
    release_rst();
    run(0);
    tick();
    chk("halt_in_decode", halt, 0);
    tick();
    chk("halt_after_decode", halt, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("halt_pc_hold", pc, 8'h04);
      chk("halt_held", halt, 1);
    end

    // PC wrap FC -> 00
    do_reset();
    clear_prog();
    jmp({6'd2, 26'h3F}, 8'hFC);
    lp = 8'hFC;
    seq(enc_i(8, 0, 7, 9), 4);
    ret_q.push_back('{3, 8'hFC});
    release_rst();
    run(0);

    // Reset during the MEM cycle of a sw
    do_reset();
    clear_prog();
    seq(enc_i(8, 0, 1, 5), 4);
    seq(enc_i(43, 0, 1, 8), 4);
    st(2, 32'h5);
    release_rst();
    run(1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
